// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl: AHB-Lite slave bridging to a byte-lane SRAM with 1-cycle read latency.
// Writes land one cycle after their address phase; a read right behind a write costs one wait state.
module ahb_sram_ctrl #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [3:0]            ram_enb,
  output logic [3:0]            ram_web,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);
  typedef enum logic [2:0] {IDLE, READ, WRITE, WR_STALL, ERR1, ERR2} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0] mask_q, mask_d, lane;
  logic acc, mis, rd_hold, unused;
  assign unused = ^{HTRANS[0], HADDR[31:ADDR_WIDTH+2]};
  assign acc = HSEL & HREADY & HTRANS[1];
  assign mis = HSIZE > 3'd2 || (HSIZE == 3'd1 && HADDR[0]) || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
  assign lane = HSIZE == 3'd0 ? 4'b0001 << HADDR[1:0] : HSIZE == 3'd1 ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // The RAM port is busy with the write, so a read arriving now must wait a cycle
  assign rd_hold = state_q == WRITE && HSEL && HTRANS[1] && !HWRITE;
  assign HREADYOUT = state_q != ERR1 && !rd_hold;
  assign HRESP = state_q == ERR1 || state_q == ERR2;
  assign HRDATA = ram_dout;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    mask_d = mask_q;
    ram_enb = state_q == WRITE ? mask_q : 4'b0000;
    ram_web = state_q == WRITE ? mask_q : 4'b0000;
    ram_addr = state_q == WRITE ? addr_q : HADDR[ADDR_WIDTH+1:2];
    ram_din = HWDATA;
    if (state_q == ERR1) state_d = ERR2;
    else if (rd_hold) state_d = WR_STALL;
    else if (!acc || rst) state_d = IDLE;
    else if (mis) state_d = ERR1;
    else if (HWRITE) begin
      state_d = WRITE;
      addr_d = HADDR[ADDR_WIDTH+1:2];
      mask_d = lane;
    end else begin
      state_d = READ;
      ram_enb = 4'b1111;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      mask_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      mask_q <= mask_d;
    end
endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb_ahb_sram_ctrl: pipelined AHB master with a byte-level memory model checking every cycle.
module tb_ahb_sram_ctrl;
  localparam int AW = 4, DEPTH = 1 << AW;
  logic clk = 0, rst = 1, ram_clr = 1;
  logic HSEL = 0, HWRITE = 0, HREADY, HREADYOUT, HRESP;
  logic [1:0] HTRANS = 0;
  logic [2:0] HSIZE = 0;
  logic [31:0] HADDR = 0, HWDATA = 0, HRDATA, ram_din, ram_dout, ram_w;
  logic [3:0] ram_enb, ram_web;
  logic [AW-1:0] ram_addr;
  logic [31:0] ram [DEPTH];
  logic [7:0] mm [4*DEPTH];
  int n_tests = 0, n_fail = 0, cyc = 0, stalls = 0, errs = 0, errs2 = 0;
  typedef struct {logic sel; logic [1:0] tr; logic wr; logic [31:0] a; logic [2:0] sz; logic [31:0] d;} tx_t;
  tx_t q[$], ap, dp;
  logic dp_v = 0;
  int dp_n = 0;
  logic [31:0] last_rd;
  logic [3:0] last_web;
  logic [AW-1:0] last_waddr;
  int w_cyc[$];

  assign HREADY = HREADYOUT;
  always #5 clk = ~clk;

  ahb_sram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .ram_enb(ram_enb), .ram_web(ram_web), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // write-first SRAM with one cycle of read latency
  always @(posedge clk)
    if (ram_clr) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      ram_dout <= '0;
    end else if (|ram_enb) begin
      ram_w = ram[ram_addr];
      for (int i = 0; i < 4; i++) if (ram_web[i]) ram_w[8*i+:8] = ram_din[8*i+:8];
      ram[ram_addr] <= ram_w;
      ram_dout <= ram_w;
    end

  function automatic logic [3:0] lanes(tx_t t);
    case (t.sz)
      3'd0: return 4'b0001 << t.a[1:0];
      3'd1: return t.a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic bad(tx_t t);
    return t.sz > 3'd2 || (t.sz == 3'd1 && t.a[0]) || (t.sz == 3'd2 && t.a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] mword(int w);
    return {mm[4*w+3], mm[4*w+2], mm[4*w+1], mm[4*w]};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tx(logic wr, logic [31:0] a, logic [2:0] sz, logic [31:0] d, logic sel = 1'b1, logic [1:0] tr = 2'b10);
    tx_t t;
    t.sel = sel; t.tr = tr; t.wr = wr; t.a = a; t.sz = sz; t.d = d;
    q.push_back(t);
  endtask

  task automatic drive();
    ap = '{1'b0, 2'b00, 1'b0, 32'h0, 3'h0, 32'h0};
    if (q.size() != 0) ap = q[0];
    HSEL = ap.sel; HTRANS = ap.tr; HWRITE = ap.wr; HADDR = ap.a; HSIZE = ap.sz;
    HWDATA = (dp_v && dp.wr) ? dp.d : $urandom;
  endtask

  task automatic step();
    logic [3:0] e_enb, e_web, m;
    logic e_rdy, e_resp, rd_on_bus, rdy;
    int e_addr;
    drive();
    @(negedge clk);
    cyc++;
    e_rdy = 1; e_resp = 0; e_enb = 0; e_web = 0; e_addr = 0;
    rd_on_bus = ap.sel && ap.tr[1] && !ap.wr;
    if (dp_v && bad(dp)) begin
      e_resp = 1;
      e_rdy = dp_n != 0;
    end else if (dp_v && dp.wr && dp_n == 0) begin
      e_enb = lanes(dp); e_web = e_enb; e_addr = int'(dp.a[AW+1:2]); e_rdy = !rd_on_bus;
      chk("ram_din", ram_din, dp.d);
      last_web = ram_web; last_waddr = ram_addr; w_cyc.push_back(cyc);
    end else if (dp_v && !dp.wr) begin
      chk("HRDATA", HRDATA, mword(int'(dp.a[AW+1:2])));
      last_rd = HRDATA;
    end
    if (e_rdy && rd_on_bus && !bad(ap)) begin
      e_enb = 4'hF; e_addr = int'(ap.a[AW+1:2]);
    end
    chk("HREADYOUT", HREADYOUT, e_rdy);
    chk("HRESP", HRESP, e_resp);
    chk("ram_enb", ram_enb, e_enb);
    chk("ram_web", ram_web, e_web);
    if (e_enb != 0) chk("ram_addr", ram_addr, e_addr);
    if (!HREADYOUT && !HRESP) stalls++;
    if (!HREADYOUT && HRESP) errs++;
    if (HREADYOUT && HRESP) errs2++;
    rdy = HREADYOUT;
    @(posedge clk);
    #1;
    if (rdy) begin
      if (dp_v && dp.wr && !bad(dp)) begin
        m = lanes(dp);
        for (int i = 0; i < 4; i++) if (m[i]) mm[4*int'(dp.a[AW+1:2])+i] = dp.d[8*i+:8];
      end
      dp_v = ap.sel && ap.tr[1];
      dp = ap;
      dp_n = 0;
      if (q.size() != 0) void'(q.pop_front());
    end else dp_n++;
  endtask

  task automatic run_q();
    int guard = 0;
    while ((q.size() != 0 || dp_v) && guard < 5000) begin
      step();
      guard++;
    end
    if (guard >= 5000) chk("drain timeout", 0, 1);
  endtask

  initial begin
    int s0, e0, f0;
    tx_t t;
    for (int i = 0; i < 4*DEPTH; i++) mm[i] = 8'h00;
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'h10; HSIZE = 3'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst HREADYOUT", HREADYOUT, 1);
    chk("rst HRESP", HRESP, 0);
    chk("rst ram_enb", ram_enb, 0);
    chk("rst ram_web", ram_web, 0);
    ram_clr = 0;
    @(posedge clk);
    #1 rst = 0;

    s0 = stalls;
    tx(1, 32'h10, 3'd2, 32'hDEADBEEF); tx(0, 0, 0, 0, 1'b1, 2'b00); tx(0, 32'h10, 3'd2, 0);
    run_q();
    chk("word wr web", last_web, 4'hF);
    chk("word wr addr", last_waddr, 4);
    chk("word rd data", last_rd, 32'hDEADBEEF);
    chk("word waits", stalls - s0, 0);

    s0 = stalls;
    tx(1, 32'h13, 3'd0, 32'hAA000000); tx(0, 32'h10, 3'd2, 0);
    run_q();
    chk("b2b stalls", stalls - s0, 1);
    chk("byte web", last_web, 4'b1000);
    chk("b2b rd data", last_rd, 32'hAAADBEEF);

    s0 = stalls;
    w_cyc.delete();
    tx(1, 32'h0, 3'd2, 32'h01010101); tx(1, 32'h4, 3'd2, 32'h02020202); tx(1, 32'h8, 3'd2, 32'h03030303);
    run_q();
    chk("burst writes", w_cyc.size(), 3);
    chk("burst span", w_cyc[2] - w_cyc[0], 2);
    chk("burst waits", stalls - s0, 0);
    tx(0, 32'h4, 3'd2, 0);
    run_q();
    chk("burst rd", last_rd, 32'h02020202);

    e0 = errs; f0 = errs2;
    tx(0, 32'h1, 3'd1, 0);
    run_q();
    chk("err1 cycles", errs - e0, 1);
    chk("err2 cycles", errs2 - f0, 1);

    tx(1, 32'h20, 3'd2, 32'h11223344);
    run_q();
    tx(1, 32'h20, 3'd2, 32'hCAFEF00D);
    step();
    drive();
    #2 rst = 1;
    #1;
    chk("rst mid-wr web", ram_web, 0);
    chk("rst mid-wr enb", ram_enb, 0);
    chk("rst mid-wr rdy", HREADYOUT, 1);
    @(posedge clk);
    #1 rst = 0;
    dp_v = 0;
    tx(0, 32'h20, 3'd2, 0);
    run_q();
    chk("rst target kept", last_rd, 32'h11223344);

    tx(0, 32'h10, 3'd2, 0, 1'b0, 2'b10); tx(1, 32'h14, 3'd2, 32'h5, 1'b0, 2'b11); tx(0, 32'h10, 3'd2, 0, 1'b0, 2'b10);
    run_q();

    for (int n = 0; n < 800; n++) begin
      t.sel = $urandom_range(0, 7) != 0;
      t.tr = 2'($urandom_range(0, 3));
      t.wr = 1'($urandom_range(0, 1));
      t.sz = $urandom_range(0, 9) < 8 ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      t.a = $urandom;
      t.d = $urandom;
      q.push_back(t);
    end
    run_q();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
